program_fetch_unit: RTL and testbench

- Initiator side of the 4-byte program-memory read interface. Drives the byte address and consumes the four registered byte outputs.
- Sequencer: holds the fetch PC, advances by 4 per issued fetch, redirects on jump, and discards stale in-flight data.
- Presents 32-bit instruction words to the core through a valid/ready handshake. A 2-entry buffer sustains 1 word/cycle under back-pressure.

---
 rtl/program_fetch_unit.sv | 125 ++++++++++++
 tb/tb_program_fetch_unit.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/program_fetch_unit.sv
// Fetch sequencer for a 4-byte program memory with a 2-entry output buffer (O + skid S).
// Define FETCH_PERF_EN to add the perf_delivered / perf_flushed counters.
module program_fetch_unit #(
    parameter int unsigned       ADDR_W     = 16,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0,
    parameter bit                LITTLE_END = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_b0,
    input  logic [7:0]        mem_b1,
    input  logic [7:0]        mem_b2,
    input  logic [7:0]        mem_b3,
    input  logic              jump,
    input  logic [ADDR_W-1:0] jump_target,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [31:0]       instr,
    output logic [ADDR_W-1:0] instr_pc
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]       perf_delivered,
    output logic [15:0]       perf_flushed
`endif
);

    localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);

    logic [ADDR_W-1:0] fetch_pc;
    logic              r_v, s_v, o_v;
    logic [ADDR_W-1:0] r_pc, s_pc, o_pc;
    logic [31:0]       s_data, o_data;
    logic [31:0]       rd_word;
    logic              pop, o_free, issue;
    logic [1:0]        occupancy;

    assign rd_word   = LITTLE_END ? {mem_b3, mem_b2, mem_b1, mem_b0}
                                  : {mem_b0, mem_b1, mem_b2, mem_b3};
    assign pop       = o_v & instr_ready;
    assign o_free    = ~o_v | pop;
    // Entries still held after this edge; an issue is allowed only if one slot stays free.
    assign occupancy = {1'b0, o_v} + {1'b0, s_v} + {1'b0, r_v} - {1'b0, pop};
    assign issue     = ~jump & (occupancy < 2'd2);

    assign mem_addr    = fetch_pc;
    assign instr_valid = o_v;
    assign instr       = o_data;
    assign instr_pc    = o_pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            r_v      <= 1'b0;
            r_pc     <= '0;
        end else if (jump) begin
            fetch_pc <= jump_target;
            r_v      <= 1'b0;
        end else begin
            r_v <= issue;
            if (issue) begin
                r_pc     <= fetch_pc;
                fetch_pc <= fetch_pc + PC_STEP;
            end
        end
    end

    // S always drains into O ahead of the returning R word so delivery order is kept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_v    <= 1'b0;
            o_pc   <= '0;
            o_data <= '0;
            s_v    <= 1'b0;
            s_pc   <= '0;
            s_data <= '0;
        end else if (jump) begin
            o_v <= 1'b0;
            s_v <= 1'b0;
        end else if (o_free) begin
            if (s_v) begin
                o_v    <= 1'b1;
                o_pc   <= s_pc;
                o_data <= s_data;
                s_v    <= r_v;
                if (r_v) begin
                    s_pc   <= r_pc;
                    s_data <= rd_word;
                end
            end else begin
                o_v <= r_v;
                if (r_v) begin
                    o_pc   <= r_pc;
                    o_data <= rd_word;
                end
            end
        end else if (r_v) begin
            s_v    <= 1'b1;
            s_pc   <= r_pc;
            s_data <= rd_word;
        end
    end

`ifdef FETCH_PERF_EN
    logic [1:0]  flush_cnt;
    logic [16:0] flushed_sum;

    // A word handshaken in the jump cycle is delivered, not flushed.
    assign flush_cnt   = {1'b0, o_v & ~pop} + {1'b0, s_v} + {1'b0, r_v};
    assign flushed_sum = {1'b0, perf_flushed} + {15'd0, flush_cnt};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_delivered <= '0;
            perf_flushed   <= '0;
        end else begin
            if (pop && (perf_delivered != '1))
                perf_delivered <= perf_delivered + 32'd1;
            if (jump)
                perf_flushed <= flushed_sum[16] ? '1 : flushed_sum[15:0];
        end
    end
`endif

endmodule

// File: tb/tb_program_fetch_unit.sv
// Scoreboard bench for program_fetch_unit: expected fetch stream queued by a PC-sequence model,
// compared by a negedge monitor on each handshake; a second instance checks RESET_PC wrap and big-endian.
`timescale 1ns/1ps
module tb_program_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] mem_addr, hi_addr;
    logic [7:0]  mb0 = '0, mb1 = '0, mb2 = '0, mb3 = '0;
    logic [7:0]  hb0 = '0, hb1 = '0, hb2 = '0, hb3 = '0;
    logic        jump;
    logic [15:0] jump_target;
    logic        instr_valid, instr_ready;
    logic [31:0] instr;
    logic [15:0] instr_pc;
    logic        hi_valid;
    logic [31:0] hi_instr;
    logic [15:0] hi_pc;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_delivered, hi_perf_d;
    logic [15:0] perf_flushed, hi_perf_f;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    program_fetch_unit #(.ADDR_W(16), .RESET_PC(16'h0000), .LITTLE_END(1'b1)) u_dut (
        .clk(clk), .rst(rst), .mem_addr(mem_addr),
        .mem_b0(mb0), .mem_b1(mb1), .mem_b2(mb2), .mem_b3(mb3),
        .jump(jump), .jump_target(jump_target),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .instr_pc(instr_pc)
`ifdef FETCH_PERF_EN
        , .perf_delivered(perf_delivered), .perf_flushed(perf_flushed)
`endif
    );

    program_fetch_unit #(.ADDR_W(16), .RESET_PC(16'hFFF8), .LITTLE_END(1'b0)) u_hi (
        .clk(clk), .rst(rst), .mem_addr(hi_addr),
        .mem_b0(hb0), .mem_b1(hb1), .mem_b2(hb2), .mem_b3(hb3),
        .jump(1'b0), .jump_target(16'h0000),
        .instr_valid(hi_valid), .instr_ready(1'b1),
        .instr(hi_instr), .instr_pc(hi_pc)
`ifdef FETCH_PERF_EN
        , .perf_delivered(hi_perf_d), .perf_flushed(hi_perf_f)
`endif
    );

    function automatic logic [7:0] mem_byte(input logic [15:0] a);
        return a[7:0] ^ a[15:8];
    endfunction

    function automatic logic [31:0] word_le(input logic [15:0] pc);
        logic [15:0] p1, p2, p3;
        p1 = pc + 16'd1; p2 = pc + 16'd2; p3 = pc + 16'd3;
        return {mem_byte(p3), mem_byte(p2), mem_byte(p1), mem_byte(pc)};
    endfunction

    function automatic logic [31:0] word_be(input logic [15:0] pc);
        logic [15:0] p1, p2, p3;
        p1 = pc + 16'd1; p2 = pc + 16'd2; p3 = pc + 16'd3;
        return {mem_byte(pc), mem_byte(p1), mem_byte(p2), mem_byte(p3)};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory: latch address on negedge, present bytes after the following posedge.
    logic [15:0] lat_addr = '0, hi_lat = '0;
    always @(negedge clk) begin
        lat_addr = mem_addr;
        hi_lat   = hi_addr;
    end
    always @(posedge clk) begin
        mb0 <= mem_byte(lat_addr);
        mb1 <= mem_byte(lat_addr + 16'd1);
        mb2 <= mem_byte(lat_addr + 16'd2);
        mb3 <= mem_byte(lat_addr + 16'd3);
        hb0 <= mem_byte(hi_lat);
        hb1 <= mem_byte(hi_lat + 16'd1);
        hb2 <= mem_byte(hi_lat + 16'd2);
        hb3 <= mem_byte(hi_lat + 16'd3);
    end

    // Reference model: the delivered stream is RESET_PC, +4, ... restarted at each jump target.
    logic [15:0] exp_q[$];
    logic [15:0] gen_pc = 16'h0000;
    logic [15:0] exp_pc;
    int          since = 0;
    int          due   = -1;
    bit          in_reset = 1'b1;
    bit          hold = 1'b0;
    logic [31:0] held_instr;
    logic [15:0] held_pc;
    int unsigned delivered = 0;

    function automatic void refill();
        while (exp_q.size() < 8) begin
            exp_q.push_back(gen_pc);
            gen_pc = gen_pc + 16'd4;
        end
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            check("rst_valid", instr_valid, 1'b0);
            check("rst_instr", instr, 32'h0);
            check("rst_pc", instr_pc, 16'h0);
`ifdef FETCH_PERF_EN
            check("rst_perf_delivered", perf_delivered, 32'd0);
`endif
            exp_q.delete();
            gen_pc    = 16'h0000;
            delivered = 0;
            in_reset  = 1'b1;
            hold      = 1'b0;
            due       = -1;
        end else begin
            if (in_reset) begin
                in_reset = 1'b0;
                since    = 0;
                due      = 2;
                check("release_valid", instr_valid, 1'b0);
            end else begin
                since++;
                if (due >= 0) begin
                    if (since < due) begin
                        check("latency_idle", instr_valid, 1'b0);
                    end else if (since == due) begin
                        check("latency_first", instr_valid, 1'b1);
                        due = -1;
                    end
                end
                if (hold) begin
                    check("hold_valid", instr_valid, 1'b1);
                    check("hold_instr", instr, held_instr);
                    check("hold_pc", instr_pc, held_pc);
                end
            end
`ifdef FETCH_PERF_EN
            check("perf_delivered", perf_delivered, 64'(delivered));
`endif
            hold = 1'b0;
            if (instr_valid && instr_ready) begin
                refill();
                exp_pc = exp_q.pop_front();
                check("word_pc", instr_pc, exp_pc);
                check("word_instr", instr, word_le(exp_pc));
                delivered++;
            end else if (instr_valid) begin
                hold       = 1'b1;
                held_instr = instr;
                held_pc    = instr_pc;
            end
            if (jump) begin
                exp_q.delete();
                gen_pc = jump_target;
                hold   = 1'b0;
                since  = 0;
                due    = 3;
            end
        end
    end

    logic [15:0] hi_exp = 16'hFFF8;
    always @(negedge clk) begin
        if (rst) begin
            hi_exp = 16'hFFF8;
        end else if (hi_valid) begin
            check("hi_pc", hi_pc, hi_exp);
            check("hi_instr_be", hi_instr, word_be(hi_exp));
            hi_exp = hi_exp + 16'd4;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic async_reset();
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("async_rst_valid", instr_valid, 1'b0);
        check("async_rst_hi_valid", hi_valid, 1'b0);
        jump = 1'b0;
        step(2);
        rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        failures++;
        $display("FAIL watchdog: got timeout expected completion at %0t", $time);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        int n;
        rst         = 1'b1;
        jump        = 1'b0;
        jump_target = '0;
        instr_ready = 1'b1;
        step(3);
        rst = 1'b0;

        n = 0;
        while (!instr_valid && n < 10) begin
            step(1);
            n++;
        end
        check("first_valid", instr_valid, 1'b1);
        check("first_wait_cycles", 64'(n), 64'd2);
        check("first_pc", instr_pc, 16'h0000);
        check("first_instr", instr, 32'h03020100);

        // Back-pressure: fetch stalls once O and S are committed.
        instr_ready = 1'b0;
        step(5);
        check("stall_fetch_pc", mem_addr, 16'h0008);
        check("stall_instr", instr, 32'h03020100);
        instr_ready = 1'b1;
        step(1);
        instr_ready = 1'b0;
        step(1);
        check("refill_fetch_pc", mem_addr, 16'h000C);

        // Jump with O and S both full.
        jump        = 1'b1;
        jump_target = 16'h0040;
        step(1);
        jump = 1'b0;
        check("jump_fetch_pc", mem_addr, 16'h0040);
        check("jump_flush_valid", instr_valid, 1'b0);
        instr_ready = 1'b1;
        step(6);

        // Jump coinciding with a handshake, unaligned target.
        check("pre_jump_valid", instr_valid, 1'b1);
        jump        = 1'b1;
        jump_target = 16'h1233;
        step(1);
        jump = 1'b0;
        step(6);

        // Mid-stream reset with ready toggling.
        for (int i = 0; i < 8; i++) begin
            instr_ready = i[0];
            step(1);
        end
        async_reset();
        instr_ready = 1'b1;
        step(10);

        for (int i = 0; i < 3000; i++) begin
            instr_ready = ($urandom_range(99) < 70);
            jump        = ($urandom_range(99) < 4);
            jump_target = 16'($urandom);
            if ($urandom_range(499) == 0)
                async_reset();
            else
                step(1);
        end
        jump        = 1'b0;
        instr_ready = 1'b1;
        step(6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
